// File: rtl/approx_adder_pipe_if.sv
// Beat-level handshake bundle for approx_adder_pipe.
// master = beat producer/consumer side, slave = the adder.
interface approx_adder_pipe_if #(
    parameter int LANES      = 4,
    parameter int WIDTH_A    = 16,
    parameter int WIDTH_B    = 16,
    parameter int MAX_IGNORE = 8
);
    localparam int BITS = (WIDTH_A > WIDTH_B) ? WIDTH_A : WIDTH_B;
    localparam int OW   = BITS + 1;
    localparam int IGW  = $clog2(MAX_IGNORE + 1);

    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH_A-1:0] in_a;
    logic [LANES*WIDTH_B-1:0] in_b;
    logic [IGW-1:0]           in_ignore;
    logic [1:0]               in_mode;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*OW-1:0]      out_sum;
    logic [LANES-1:0]         out_sat;

    modport master (
        output in_valid, in_a, in_b, in_ignore, in_mode, out_ready,
        input  in_ready, out_valid, out_sum, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, in_ignore, in_mode, out_ready,
        output in_ready, out_valid, out_sum, out_sat
    );
endinterface

// File: rtl/approx_adder_pipe.sv
// Multi-lane two-stage approximate adder.
// Stage 1 sign-extends and LSB-truncates the operands; stage 2 adds them and
// applies the per-beat overflow mode (wrap / saturate / full precision).
// Mode travels with each beat, so changing it beat to beat costs no bubbles.
module approx_adder_pipe #(
    parameter int LANES      = 4,
    parameter int WIDTH_A    = 16,
    parameter int WIDTH_B    = 16,
    parameter int MAX_IGNORE = 8,
    parameter int TRUNC_FILL = 0
) (
    input  logic                clk,
    input  logic                rst,
    approx_adder_pipe_if.slave  bus
);
    localparam int BITS = (WIDTH_A > WIDTH_B) ? WIDTH_A : WIDTH_B;
    localparam int OW   = BITS + 1;
    localparam int IGW  = $clog2(MAX_IGNORE + 1);

    localparam logic [OW-1:0] POS_LIM = {2'b00, {(BITS-1){1'b1}}};
    localparam logic [OW-1:0] NEG_LIM = {2'b11, {(BITS-1){1'b0}}};

    logic                s1_valid_q;
    logic [BITS-1:0]     a_q [LANES];
    logic [BITS-1:0]     b_q [LANES];
    logic [1:0]          mode_q;
    logic                s2_valid_q;
    logic [LANES*OW-1:0] sum_q;
    logic [LANES-1:0]    sat_q;

    logic                s1_ready;
    logic                s2_ready;
    logic [IGW-1:0]      k_clamped;
    logic [BITS-1:0]     trunc_mask;
    logic [BITS-1:0]     fill_bits;
    logic [BITS-1:0]     a_d [LANES];
    logic [BITS-1:0]     b_d [LANES];
    logic [OW-1:0]       s_full;
    logic                ovf;
    logic [LANES*OW-1:0] sum_d;
    logic [LANES-1:0]    sat_d;

    // Each stage may accept whenever it is empty or is being drained this cycle.
    assign s2_ready     = !s2_valid_q || bus.out_ready;
    assign s1_ready     = !s1_valid_q || s2_ready;
    assign bus.in_ready = s1_ready;

    assign bus.out_valid = s2_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_sat   = sat_q;

    // Stage 1 datapath: sign-extend to BITS and overwrite the k ignored LSBs.
    always_comb begin
        k_clamped  = (bus.in_ignore > IGW'(MAX_IGNORE)) ? IGW'(MAX_IGNORE) : bus.in_ignore;
        trunc_mask = (BITS'(1) << k_clamped) - BITS'(1);
        fill_bits  = (TRUNC_FILL != 0) ? trunc_mask : '0;
        for (int i = 0; i < LANES; i++) begin
            a_d[i] = (BITS'($signed(bus.in_a[i*WIDTH_A +: WIDTH_A])) & ~trunc_mask) | fill_bits;
            b_d[i] = (BITS'($signed(bus.in_b[i*WIDTH_B +: WIDTH_B])) & ~trunc_mask) | fill_bits;
        end
    end

    // Stage 1 registers: capture prepared operands and the beat's mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            mode_q     <= 2'b00;
            for (int i = 0; i < LANES; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else if (s1_ready) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                mode_q <= bus.in_mode;
                for (int i = 0; i < LANES; i++) begin
                    a_q[i] <= a_d[i];
                    b_q[i] <= b_d[i];
                end
            end
        end
    end

    // Stage 2 datapath: exact OW-bit sum, then wrap / clamp / pass per mode.
    // Mode 11 falls into the default arm and behaves as wrap.
    always_comb begin
        sum_d  = '0;
        sat_d  = '0;
        s_full = '0;
        ovf    = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            s_full = {a_q[i][BITS-1], a_q[i]} + {b_q[i][BITS-1], b_q[i]};
            ovf    = s_full[BITS] ^ s_full[BITS-1];
            case (mode_q)
                2'b01: begin
                    if (ovf) begin
                        sum_d[i*OW +: OW] = s_full[BITS] ? NEG_LIM : POS_LIM;
                    end else begin
                        sum_d[i*OW +: OW] = s_full;
                    end
                    sat_d[i] = ovf;
                end
                2'b10: begin
                    sum_d[i*OW +: OW] = s_full;
                    sat_d[i]          = 1'b0;
                end
                default: begin
                    sum_d[i*OW +: OW] = {s_full[BITS-1], s_full[BITS-1:0]};
                    sat_d[i]          = ovf;
                end
            endcase
        end
    end

    // Stage 2 registers: output beat; holds while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            sat_q      <= '0;
        end else if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q <= sum_d;
                sat_q <= sat_d;
            end
        end
    end
endmodule

// File: doc/approx_adder_pipe.md
Name: approx_adder_pipe

Overview:
Multi-lane, pipelined approximate adder for the systolic-array datapath. It is the parametrised successor of the single-lane combinational truncating adder. Per beat, it adds LANES operand pairs with a runtime-selectable number of ignored LSBs and one of three overflow modes. A two-stage valid/ready pipeline lets it sit between PE accumulation stages and tolerate backpressure.

Parameters:
LANES, 4, number of independent adder lanes
WIDTH_A, 16, width of each A operand (signed, two's complement)
WIDTH_B, 16, width of each B operand (signed, two's complement)
MAX_IGNORE, 8, largest legal LSB truncation count; must be < BITS
TRUNC_FILL, 0, value (0 or 1) written into each ignored LSB
Derived: BITS = max(WIDTH_A, WIDTH_B); OW = BITS+1; IGW = clog2(MAX_IGNORE+1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_a  in  LANES*WIDTH_A  lane i operand A at [i*WIDTH_A +: WIDTH_A]
in_b  in  LANES*WIDTH_B  lane i operand B at [i*WIDTH_B +: WIDTH_B]
in_ignore  in  IGW  LSBs to ignore for this beat
in_mode  in  2  00 wrap, 01 saturate, 10 full precision, 11 treated as 00
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_sum  out  LANES*OW  lane i result at [i*OW +: OW]
out_sat  out  LANES  per-lane overflow flag for this beat

Behaviour:
- One clock and one asynchronous active-high reset. The design uses only the rising edge of clk.
- Reset (async assert): s1/s2 valids = 0; out_valid = 0; out_sum = 0; out_sat = 0. in_ready = 1 while rst is high and after release. Beats in flight are discarded.
- Stage 1 (capture on in_valid && in_ready):
  - Sign-extend A and B to BITS.
  - Clamp k = min(in_ignore, MAX_IGNORE).
  - Replace bits [k-1:0] of each operand with TRUNC_FILL; k = 0 leaves the operands unchanged.
  - Register the operands with the per-beat mode.
- Stage 2 (advance when s2 is empty or drained):
  - Compute S = A' + B' at OW bits (exact).
  - Overflow condition: S[BITS] != S[BITS-1].
  - Mode 00: out = sign-extend(S[BITS-1:0]) to OW; out_sat = overflow.
  - Mode 01: on overflow, clamp to +2^(BITS-1)-1 or -2^(BITS-1), chosen by S[BITS]; out_sat = overflow; otherwise out = S.
  - Mode 10: out = S; out_sat = 0.
- Mode and ignore count travel with each beat. Per-beat changes take effect without bubbles.
- Handshake:
  - s2_ready = !s2_valid || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready (combinational chain; no combinational path from in_valid to in_ready).
- Latency: accepted beat appears on out_valid 2 cycles later when unstalled. Throughput is 1 beat/cycle with out_ready held high.
- Stall: while out_valid && !out_ready, out_sum and out_sat hold stable. The pipeline holds up to 2 beats; beyond that, in_ready = 0.
- Beat order is preserved. No beat is dropped or duplicated.
- Simultaneous accept and drain in the same cycle is legal at every stage.
- Lanes are fully independent; no cross-lane carry.

Test Plan:
- Lane0 A=0x7FFF, B=0x0001, k=0, WIDTH_A=WIDTH_B=16, BITS=16, OW=17, three beats in modes 00/01/10 -> out_sum 0x18000 sat=1; 0x07FFF sat=1; 0x08000 sat=0, in order, each 2 cycles after accept.
- A=0x8000, B=0xFFFF, mode 01 -> 0x18000 (-32768), sat=1. Same operands in mode 10 -> 0x17FFF, sat=0.
- A=0x00FF, B=0x0003, k=4, mode 10, TRUNC_FILL=0 -> 0x000F0. Rebuild with TRUNC_FILL=1, A=B=0x0000, k=4 -> 0x0001E.
- in_ignore=15 with MAX_IGNORE=8 and IGW=4 -> result identical to in_ignore=8.
- Stream 5 back-to-back beats; drop out_ready for 3 cycles after the first out_valid -> in_ready falls after 2 beats are buffered, out_sum stays stable while stalled, all 5 results arrive in order with none lost.
- Assert rst for 1 cycle with both stages valid -> out_valid=0 and out_sum=0 immediately (async). No stale beat appears after release; the next accepted beat has 2-cycle latency.
